ram_dp_be: RTL and testbench
============================

Name: ram_dp_be

Overview:
- Parametrised simple dual-port RAM: one write port and one read port on a single clock.
- Next-generation data/instruction store for the core; replaces the single-port fixed 32x32 store.
- Adds per-byte write enables, selectable read latency and read-during-write mode.
- Adds a hardware clear sequencer that zeroes the whole array after every reset.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of BYTE_W.
- DEPTH, 32, number of words; need not be a power of two.
- BYTE_W, 8, width of one write-enable lane.
- READ_LAT, 1, read latency in cycles; legal values 1 or 2.
- READ_MODE, 0, same-address read/write collision policy: 0 = old data, 1 = new data (write-first).

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request, active high
- wr_addr  in  ADDR_W  write address, ADDR_W = $clog2(DEPTH)
- wr_be  in  NBYTES  byte enables, NBYTES = DATA_W/BYTE_W; bit i covers bits [i*BYTE_W +: BYTE_W]
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request, active high
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  read data
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_perr  out  1  parity error on the current read (see Optional Feature)
- init_done  out  1  high once the clear sequence has completed

Behaviour:
- Reset values: rd_data=0, rd_valid=0, rd_perr=0, init_done=0; read pipeline flushed. Memory array is not reset directly.
- FSM states: CLEAR, READY.
  - rst_n low forces CLEAR with clr_addr=0.
  - In CLEAR, one word per cycle: word clr_addr is written with all zeros, then clr_addr increments.
  - After writing DEPTH-1, transition to READY; init_done=1 in the following cycle and stays high until the next reset.
  - The clear sequence takes exactly DEPTH cycles after rst_n release.
- While init_done=0, wr_en and rd_en are ignored: no array write from the ports, no rd_valid.
- Write (READY):
  - At the posedge with wr_en=1, only the lanes with wr_be[i]=1 are updated.
  - wr_be=0 with wr_en=1 is a legal no-op.
- Read (READY):
  - rd_en=1 at edge N produces rd_valid=1 and rd_data at edge N+READ_LAT.
  - Back-to-back reads are supported at one per cycle.
  - rd_data holds its last value while rd_valid=0.
- Collision (wr_en and rd_en both high, wr_addr==rd_addr, same edge):
  - READ_MODE=0: rd_data returns the pre-write word.
  - READ_MODE=1: rd_data returns the merged word, i.e. old bytes plus the newly enabled bytes.
- Addresses >= DEPTH: writes are dropped; reads return 0 with rd_valid=1 as normal.
- Reset mid-operation:
  - In-flight reads are discarded, with no rd_valid after reset.
  - A reset during CLEAR restarts the sequence at address 0.
- Illegal parameters (DATA_W % BYTE_W != 0, or READ_LAT not in {1,2}): elaboration-time $error.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - Each byte lane stores one extra even-parity bit, computed from wr_data on write.
  - The clear sequence writes parity 0.
  - On read, parity is recomputed; rd_perr=1 in the same cycle as rd_valid if any lane mismatches.
- Undefined: no parity storage; rd_perr is tied to 0.

Decomposition:
- Package ram_pkg holds:
  - state enum ram_state_e {CLEAR, READY};
  - constants RD_OLD=0 and RD_NEW=1;
  - function byte_parity(), for even parity per lane.
- Sub-module ram_init_seq contains the CLEAR/READY FSM, the clr_addr counter and init_done. It drives the array's write mux.
- The array, byte-merge logic and read pipeline stay in ram_dp_be.

Test Plan:
- Clear sequence (DEPTH=32):
  - Release rst_n -> init_done rises exactly 32 cycles later.
  - Then read all 32 addresses -> every rd_data is 0x00000000.
- Byte-enable write:
  - Write 0xDEADBEEF to addr 5 with be=4'b1111, then 0x11223344 with be=4'b0101.
  - Read addr 5 -> 0xDE22BE44.
- Read latency:
  - READ_LAT=2, read on 3 consecutive cycles -> 3 rd_valid pulses.
  - Each pulse arrives 2 cycles after its request, in order.
- Collision at addr 7 (addr 7 holds 0xAAAAAAAA):
  - Same-edge write of 0x55555555 with be=4'b0011, plus a read.
  - READ_MODE=0 -> 0xAAAAAAAA; READ_MODE=1 -> 0xAAAA5555.
- Reset mid-read and mid-clear:
  - Assert rst_n low one cycle after rd_en -> no rd_valid; rd_data=0.
  - Release -> init_done low again for DEPTH cycles.
- With RAM_PARITY_EN:
  - Force-flip one stored bit of addr 3 via hierarchical deposit.
  - Read addr 3 -> rd_perr=1 coincident with rd_valid; other addresses give rd_perr=0.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_dp_be store: init FSM states, collision modes, lane parity.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

  localparam int RD_OLD     = 0;
  localparam int RD_NEW     = 1;
  localparam int MAX_BYTE_W = 64;

  // Callers zero-extend a lane to MAX_BYTE_W; zero padding leaves even parity unchanged.
  function automatic logic byte_parity(input logic [MAX_BYTE_W-1:0] lane);
    return ^lane;
  endfunction

endpackage

// File: rtl/ram_init_seq.sv
// Post-reset clear sequencer: zeroes one word per cycle for DEPTH cycles, then raises init_done.
// Owns the array write mux select (clr_we_o/clr_addr_o); no backpressure.
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic              init_done_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ram_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              init_done_q, init_done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      clr_addr_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    init_done_d = init_done_q;
    clr_we_o    = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we_o = 1'b1;
        if (clr_addr_q == LAST_ADDR) begin
          state_d     = READY;
          init_done_d = 1'b1;
          clr_addr_d  = '0;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      READY: begin
        init_done_d = 1'b1;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  assign clr_addr_o  = clr_addr_q;
  assign init_done_o = init_done_q;

endmodule

// File: rtl/ram_dp_be.sv
// ram_dp_be: 1W/1R RAM with byte enables, READ_LAT-cycle reads, no backpressure; self-clears after reset.
// Define RAM_PARITY_EN to store one even-parity bit per byte lane and flag mismatches on rd_perr.
module ram_dp_be
  import ram_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int DEPTH     = 32,
  parameter  int BYTE_W    = 8,
  parameter  int READ_LAT  = 1,
  parameter  int READ_MODE = 0,
  localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NBYTES    = DATA_W / BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [NBYTES-1:0] wr_be,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_perr,
  output logic              init_done
);

  if ((DATA_W % BYTE_W != 0) || (BYTE_W > MAX_BYTE_W)) begin : g_bad_byte_w
    $error("ram_dp_be: DATA_W (%0d) must be a multiple of BYTE_W (%0d)", DATA_W, BYTE_W);
  end
  if ((READ_LAT != 1) && (READ_LAT != 2)) begin : g_bad_read_lat
    $error("ram_dp_be: READ_LAT (%0d) must be 1 or 2", READ_LAT);
  end

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  ram_init_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_init_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_we_o    (clr_we),
    .clr_addr_o  (clr_addr),
    .init_done_o (init_done)
  );

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok, rd_req, rd_in_range, collide, rd_err;
  logic [DATA_W-1:0] wr_word, rd_word;

  assign wr_ok       = init_done && wr_en && ({1'b0, wr_addr} < DEPTH_L);
  assign rd_req      = init_done && rd_en;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_L;
  assign collide     = wr_ok && (wr_addr == rd_addr);

  always_comb begin
    wr_word = mem[wr_addr];
    for (int i = 0; i < NBYTES; i++) begin
      if (wr_be[i]) wr_word[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
    end
  end

  // On a collision the merged write word is exactly what the write-first mode must return.
  assign rd_word = !rd_in_range                       ? '0 :
                   (READ_MODE == RD_NEW && collide)   ? wr_word :
                                                        mem[rd_addr];

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_word;
    end
  end

`ifdef RAM_PARITY_EN
  logic [NBYTES-1:0] par_mem [DEPTH];
  logic [NBYTES-1:0] wr_par, rd_par, rd_err_bits;

  always_comb begin
    wr_par = par_mem[wr_addr];
    for (int i = 0; i < NBYTES; i++) begin
      if (wr_be[i]) wr_par[i] = byte_parity(MAX_BYTE_W'(wr_data[i*BYTE_W +: BYTE_W]));
    end
  end

  assign rd_par = (READ_MODE == RD_NEW && collide) ? wr_par : par_mem[rd_addr];

  always_comb begin
    rd_err_bits = '0;
    for (int i = 0; i < NBYTES; i++) begin
      rd_err_bits[i] = byte_parity(MAX_BYTE_W'(rd_word[i*BYTE_W +: BYTE_W])) ^ rd_par[i];
    end
  end

  assign rd_err = rd_in_range && (|rd_err_bits);

  always_ff @(posedge clk) begin
    if (clr_we) begin
      par_mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      par_mem[wr_addr] <= wr_par;
    end
  end
`else
  assign rd_err = 1'b0;
`endif

  logic              pipe_vld_q, pipe_err_q;
  logic [DATA_W-1:0] pipe_dat_q;
  logic              rd_valid_q, rd_valid_d, rd_perr_q, rd_perr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  assign rd_valid_d = (READ_LAT == 2) ? pipe_vld_q : rd_req;
  assign rd_data_d  = (READ_LAT == 2) ? pipe_dat_q : rd_word;
  assign rd_perr_d  = (READ_LAT == 2) ? pipe_err_q : rd_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= 1'b0;
      pipe_dat_q <= '0;
      pipe_err_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_perr_q  <= 1'b0;
    end else begin
      pipe_vld_q <= rd_req;
      if (rd_req) begin
        pipe_dat_q <= rd_word;
        pipe_err_q <= rd_err;
      end
      rd_valid_q <= rd_valid_d;
      rd_perr_q  <= rd_valid_d && rd_perr_d;
      if (rd_valid_d) rd_data_q <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_perr  = rd_perr_q;

endmodule

// File: tb/tb_ram_dp_be.sv
// Scoreboard bench: two ram_dp_be instances (32 deep/lat 1/old-data and 20 deep/lat 2/write-first) on shared stimulus.
module tb_ram_dp_be;

  localparam int D1 = 32;
  localparam int D2 = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [4:0]  wr_addr = '0, rd_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] dat1, dat2;
  logic        vld1, vld2, perr1, perr2, done1, done2;

  always #5 clk = ~clk;

  ram_dp_be #(.DATA_W(32), .DEPTH(D1), .BYTE_W(8), .READ_LAT(1), .READ_MODE(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dat1), .rd_valid(vld1), .rd_perr(perr1), .init_done(done1)
  );

  ram_dp_be #(.DATA_W(32), .DEPTH(D2), .BYTE_W(8), .READ_LAT(2), .READ_MODE(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dat2), .rd_valid(vld2), .rd_perr(perr2), .init_done(done2)
  );

  typedef struct {
    logic [31:0] dat;
    int          due;
    logic        perr;
  } exp_t;

  exp_t        q1[$], q2[$];
  logic [31:0] m1 [32];
  logic [31:0] m2 [32];
  int          cyc = 0, n_chk = 0, n_pass = 0, bad_addr = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    merge = old;
    for (int i = 0; i < 4; i++) if (be[i]) merge[i*8 +: 8] = nw[i*8 +: 8];
  endfunction

  // Drive one cycle of stimulus; expectations are pushed before the model sees the write.
  task automatic step(input logic we, input logic [4:0] wa, input logic [3:0] be, input logic [31:0] wd,
                      input logic re, input logic [4:0] ra);
    exp_t e;
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd; rd_en = re; rd_addr = ra;
    if (re) begin
      e.perr = (int'(ra) == bad_addr);
      e.due  = cyc + 1;
      e.dat  = m1[ra];
      q1.push_back(e);
      e.due = cyc + 2;
      if (ra >= 5'(D2)) begin
        e.dat  = '0;
        e.perr = 1'b0;
      end else if (we && wa == ra) begin
        e.dat = merge(m2[ra], wd, be);
      end else begin
        e.dat = m2[ra];
      end
      q2.push_back(e);
    end
    if (we) begin
      m1[wa] = merge(m1[wa], wd, be);
      if (wa < 5'(D2)) m2[wa] = merge(m2[wa], wd, be);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic assert_reset();
    @(negedge clk);
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    q1.delete();
    q2.delete();
  endtask

  // Junk port traffic during the clear must be ignored by both instances.
  task automatic release_and_count(input bit junk);
    int n1, n2;
    n1 = 0; n2 = 0;
    for (int i = 0; i < 32; i++) begin m1[i] = '0; m2[i] = '0; end
    @(negedge clk);
    if (junk) begin
      wr_en = 1'b1; wr_addr = 5'd0; wr_be = 4'hF; wr_data = 32'hFFFF_FFFF; rd_en = 1'b1; rd_addr = 5'd1;
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 100 && (n1 == 0 || n2 == 0); n++) begin
      @(posedge clk);
      #1;
      if (n == 16) begin wr_en = 1'b0; rd_en = 1'b0; end
      if (done1 && n1 == 0) n1 = n;
      if (done2 && n2 == 0) n2 = n;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    chk("d1_clear_cycles", n1, D1);
    chk("d2_clear_cycles", n2, D2);
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (vld1) begin
      if (q1.size() == 0) chk("d1_unexpected_valid", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("d1_rd_data", dat1, e.dat);
        chk("d1_latency", cyc, e.due);
        chk("d1_rd_perr", {31'd0, perr1}, {31'd0, e.perr});
      end
    end
    if (vld2) begin
      if (q2.size() == 0) chk("d2_unexpected_valid", 32'd1, 32'd0);
      else begin
        e = q2.pop_front();
        chk("d2_rd_data", dat2, e.dat);
        chk("d2_latency", cyc, e.due);
        chk("d2_rd_perr", {31'd0, perr2}, {31'd0, e.perr});
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_data1", dat1, 32'h0);
    chk("rst_rd_data2", dat2, 32'h0);
    chk("rst_flags1", {28'd0, vld1, perr1, done1, 1'b0}, 32'h0);
    chk("rst_flags2", {28'd0, vld2, perr2, done2, 1'b0}, 32'h0);
    release_and_count(1'b1);

    for (int a = 0; a < 32; a++) step(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'(a));
    idle(3);

    // Byte lanes: expect 0xDE22BE44 at addr 5, then a be=0 write must change nothing.
    step(1'b1, 5'd5, 4'b1111, 32'hDEAD_BEEF, 1'b0, 5'd0);
    step(1'b1, 5'd5, 4'b0101, 32'h1122_3344, 1'b0, 5'd0);
    step(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd5);
    step(1'b1, 5'd5, 4'b0000, 32'hFFFF_FFFF, 1'b0, 5'd0);
    step(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd5);

    // Address 19 is the last word of the 20-deep instance; 25 and 31 lie beyond it.
    step(1'b1, 5'd25, 4'hF, 32'hCAFE_F00D, 1'b0, 5'd0);
    step(1'b1, 5'd19, 4'hF, 32'h0BAD_C0DE, 1'b0, 5'd0);
    step(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd5);
    step(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd19);
    step(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd25);
    idle(3);

    step(1'b1, 5'd7, 4'hF, 32'hAAAA_AAAA, 1'b0, 5'd0);
    step(1'b1, 5'd7, 4'b0011, 32'h5555_5555, 1'b1, 5'd7);
    step(1'b1, 5'd8, 4'hF, 32'h0123_4567, 1'b1, 5'd7);
    step(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd8);
    idle(3);

    // Reset one cycle after a read request: the latency-2 read must never surface.
    step(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd5);
    assert_reset();
    #1;
    chk("midread_rd_data1", dat1, 32'h0);
    chk("midread_rd_data2", dat2, 32'h0);
    chk("midread_flags", {28'd0, vld1, vld2, done1, done2}, 32'h0);
    repeat (3) @(posedge clk);
    release_and_count(1'b0);

    step(1'b1, 5'd2, 4'hF, 32'h1234_5678, 1'b0, 5'd0);
    step(1'b1, 5'd30, 4'hF, 32'h8765_4321, 1'b0, 5'd0);
    idle(1);
    assert_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    assert_reset();
    repeat (2) @(posedge clk);
    release_and_count(1'b0);
    step(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd2);
    step(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd30);
    idle(3);

`ifdef RAM_PARITY_EN
    step(1'b1, 5'd3, 4'hF, 32'h0F0F_0F0F, 1'b0, 5'd0);
    #1;
    u_dut1.mem[3][0] = ~u_dut1.mem[3][0];
    u_dut2.mem[3][0] = ~u_dut2.mem[3][0];
    m1[3][0] = ~m1[3][0];
    m2[3][0] = ~m2[3][0];
    bad_addr = 3;
    step(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd3);
    step(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd4);
    idle(3);
`endif

    idle(2);
    chk("d1_queue_drained", q1.size(), 32'd0);
    chk("d2_queue_drained", q2.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
